fft_frame_sched: RTL and testbench

- Frame-level scheduler for a chain of radix-2 FFT stage PEs.
- Latches per-frame configuration: source select (external input vs. parallel/loopback bus) and per-stage scaling shift.
- Gates the selected source into the chain for exactly POINT samples.
- Counts POINT valid outputs from the last stage, then signals frame completion; flags overrun, spurious-output and stall errors.

---
 rtl/fft_frame_sched.sv | 199 +++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Frame-level scheduler for a radix-2 FFT PE chain: latches per-frame source/scaling,
// gates exactly POINT input samples, counts POINT last-stage outputs and flags errors.
module fft_frame_sched #(
    parameter int POINT   = 512,
    parameter int STAGES  = $clog2(POINT),
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr,
    input  logic                  cfg_src,
    input  logic [2*STAGES-1:0]   cfg_scaling,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  par_valid,
    output logic                  par_ready,
    output logic                  select,
    output logic [2*STAGES-1:0]   scaling,
    input  logic                  last_valid,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_cnt,
    output logic [2:0]            err
);

    localparam int CW = $clog2(POINT) + 1;
    localparam int SW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] POINT_C   = CW'(POINT);
    localparam logic [CW-1:0] LAST_IN   = CW'(POINT - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  src_q, src_d;
    logic [2*STAGES-1:0]   scal_q, scal_d;
    logic [CW-1:0]         in_cnt_q, in_cnt_d;
    logic [CW-1:0]         out_cnt_q, out_cnt_d;
    logic [SW-1:0]         stall_q, stall_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [2:0]            err_q, err_d;

    logic                  in_load;
    logic                  sel_valid;
    logic                  accept;
    logic                  out_counting;
    logic                  out_inc;
    logic [CW-1:0]         in_cnt_nx;
    logic [CW-1:0]         out_cnt_nx;
    logic [2:0]            err_new;
    logic [2:0]            err_base;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        scal_d      = scal_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        stall_d     = stall_q;
        frame_cnt_d = frame_cnt_q;
        err_new     = 3'b000;
        err_base    = err_q;

        in_load   = (state_q == S_LOAD);
        sel_valid = src_q ? par_valid : in_valid;
        accept    = sel_valid & in_load;

        // The selected source is only ever ready in LOAD; anything offered elsewhere is lost.
        if (sel_valid && !in_load) begin
            err_new[0] = 1'b1;
        end
        if (last_valid && (state_q == S_IDLE || state_q == S_DONE)) begin
            err_new[1] = 1'b1;
        end

        out_counting = last_valid && (state_q == S_LOAD || state_q == S_DRAIN);
        out_inc      = out_counting && (out_cnt_q != POINT_C);
        if (out_counting && (out_cnt_q == POINT_C)) begin
            err_new[1] = 1'b1;
        end

        in_cnt_nx  = in_cnt_q + CW'(accept);
        out_cnt_nx = out_cnt_q + CW'(out_inc);

        case (state_q)
            S_IDLE: begin
                if (cfg_wr) begin
                    src_d    = cfg_src;
                    scal_d   = cfg_scaling;
                    err_base = 3'b000;
                end
                if (start) begin
                    state_d   = S_LOAD;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    stall_d   = '0;
                end
            end
            S_LOAD: begin
                in_cnt_d  = in_cnt_nx;
                out_cnt_d = out_cnt_nx;
                if (accept && (in_cnt_q == LAST_IN)) begin
                    stall_d = '0;
                    // Final input and final output on the same edge skip DRAIN entirely.
                    if (out_cnt_nx == POINT_C) begin
                        state_d     = S_DONE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                out_cnt_d = out_cnt_nx;
                if (last_valid) begin
                    stall_d = '0;
                    if ((out_cnt_nx == POINT_C) && (in_cnt_q == POINT_C)) begin
                        state_d     = S_DONE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end else if (stall_q == STALL_MAX) begin
                    err_new[2] = 1'b1;
                    state_d    = S_IDLE;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    stall_d    = '0;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                in_cnt_d  = '0;
                out_cnt_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = err_base | err_new;

        // Abort wins over every transition, but leaves the completion count and error flags alone.
        if (abort) begin
            state_d     = S_IDLE;
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            stall_d     = '0;
            src_d       = src_q;
            scal_d      = scal_q;
            frame_cnt_d = frame_cnt_q;
            err_d       = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= 1'b0;
            scal_q      <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            stall_q     <= '0;
            frame_cnt_q <= 16'd0;
            err_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            scal_q      <= scal_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            stall_q     <= stall_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD) & ~src_q;
    assign par_ready = (state_q == S_LOAD) & src_q;
    assign select    = src_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_scal
            assign scaling[2*gi +: 2] = scal_q[2*gi +: 2];
        end
    endgenerate

endmodule

// File: tb/tb_fft_frame_sched.sv
// Randomized scoreboard bench for fft_frame_sched (POINT=8, TIMEOUT=16).
module tb_fft_frame_sched;

    localparam int POINT   = 8;
    localparam int STAGES  = 3;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_wr;
    logic                cfg_src;
    logic [2*STAGES-1:0] cfg_scaling;
    logic                start;
    logic                abort;
    logic                in_valid;
    logic                in_ready;
    logic                par_valid;
    logic                par_ready;
    logic                select;
    logic [2*STAGES-1:0] scaling;
    logic                last_valid;
    logic                busy;
    logic                done;
    logic [15:0]         frame_cnt;
    logic [2:0]          err;

    fft_frame_sched #(.POINT(POINT), .STAGES(STAGES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_src(cfg_src), .cfg_scaling(cfg_scaling),
        .start(start), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .par_valid(par_valid), .par_ready(par_ready), .select(select), .scaling(scaling),
        .last_valid(last_valid), .busy(busy), .done(done), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [5:0]  scal;
        logic [15:0] fcnt;
        logic [2:0]  err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   in_hi_cnt = 0;
    int   par_hi_cnt = 0;
    int   done_cnt = 0;
    int   exp_fcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    // Monitor: ready occupancy and completion events, compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            in_hi_cnt  += int'(in_ready);
            par_hi_cnt += int'(par_ready);
            if (done) begin
                done_cnt++;
                check("done_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("done_select", 32'(select), 32'(mon_e.sel));
                    check("done_scaling", 32'(scaling), 32'(mon_e.scal));
                    check("done_frame_cnt", 32'(frame_cnt), 32'(mon_e.fcnt));
                    check("done_err", 32'(err), 32'(mon_e.err));
                    $display("[TB] frame done: select=%0d scaling=%02h frame_cnt=%0d err=%0b",
                             select, scaling, frame_cnt, err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cfg_wr = 1'b0; cfg_src = 1'b0; cfg_scaling = '0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; par_valid = 1'b0; last_valid = 1'b0;
    endtask

    // Configure + start, then feed POINT samples; ready must be up for every LOAD cycle.
    task automatic load_phase(input bit src, input logic [5:0] scal, input int vmode,
                              input bit noise, input bit overlap,
                              output int outs_sent, output int load_cycles);
        int in_acc = 0;
        int osent  = 0;
        int cyc    = 0;
        bit v;
        bit lv;
        cfg_wr = 1'b1; cfg_src = src; cfg_scaling = scal; start = 1'b1;
        tick();
        cfg_wr = 1'b0; start = 1'b0;
        while (in_acc < POINT) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(99) < 60) || (cyc > 40);
            endcase
            lv = overlap && ($urandom_range(1) == 1) && (osent < in_acc + int'(v));
            if (src) begin
                par_valid = v;
                in_valid  = noise ? 1'($urandom_range(1)) : 1'b0;
            end else begin
                in_valid  = v;
                par_valid = noise ? 1'($urandom_range(1)) : 1'b0;
            end
            last_valid = lv;
            check("ready_sel_load", 32'(src ? par_ready : in_ready), 32'd1);
            check("ready_other_load", 32'(src ? in_ready : par_ready), 32'd0);
            in_acc += int'(v);
            osent  += int'(lv);
            cyc++;
            tick();
        end
        in_valid = 1'b0; par_valid = 1'b0; last_valid = 1'b0;
        outs_sent   = osent;
        load_cycles = cyc;
    endtask

    task automatic run_frame(input bit src, input logic [5:0] scal, input int vmode,
                             input bit noise, input bit overlap);
        int i0 = in_hi_cnt;
        int p0 = par_hi_cnt;
        int d0 = done_cnt;
        int osent;
        int lc;
        exp_t e;
        e.sel = src; e.scal = scal; e.fcnt = 16'(exp_fcnt + 1); e.err = 3'b000;
        sb_q.push_back(e);
        exp_fcnt++;
        load_phase(src, scal, vmode, noise, overlap, osent, lc);
        check("ready_low_after_load", 32'({in_ready, par_ready}), 32'd0);
        while (osent < POINT) begin
            repeat ($urandom_range(4)) tick();
            last_valid = 1'b1;
            tick();
            last_valid = 1'b0;
            osent++;
        end
        tick();
        tick();
        check("frame_idle", 32'(busy), 32'd0);
        check("frame_cnt_after", 32'(frame_cnt), 32'(exp_fcnt));
        check("frame_err", 32'(err), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("sel_ready_cycles", 32'(src ? par_hi_cnt - p0 : in_hi_cnt - i0), 32'(lc));
        check("other_ready_cycles", 32'(src ? in_hi_cnt - i0 : par_hi_cnt - p0), 32'd0);
        $display("[TB] frame src=%0d scal=%02h load_cycles=%0d frame_cnt=%0d err=%0b",
                 src, scal, lc, frame_cnt, err);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int osent;
        int lc;
        int silent;
        int d0;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_readys", 32'({in_ready, par_ready}), 32'd0);
        check("rst_select", 32'(select), 32'd0);
        check("rst_scaling", 32'(scaling), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Gapless frame from the external bus, all stages scaled by 1.
        run_frame(1'b0, 6'b010101, 0, 1'b0, 1'b0);
        // Loopback bus with a valid every other cycle and noise on the external bus.
        run_frame(1'b1, 6'($urandom), 1, 1'b1, 1'b0);

        // Overrun detection in IDLE; non-selected source is not an error; cfg_wr clears.
        cfg_wr = 1'b1; cfg_src = 1'b0; cfg_scaling = '0;
        tick();
        cfg_wr = 1'b0;
        par_valid = 1'b1; tick(); par_valid = 1'b0; tick();
        check("err_nonsel_idle", 32'(err), 32'd0);
        in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
        check("err_overrun", 32'(err), 32'b001);
        $display("[TB] overrun in IDLE: err=%0b", err);
        cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);

        // Timeout: only 5 of 8 outputs, then silence.
        d0 = done_cnt;
        load_phase(1'b0, 6'h3f, 0, 1'b0, 1'b0, osent, lc);
        repeat (5) begin
            last_valid = 1'b1;
            tick();
        end
        last_valid = 1'b0;
        silent = 0;
        while (busy === 1'b1 && silent < TIMEOUT + 8) begin
            tick();
            silent++;
        end
        tick();
        check("timeout_cycles", 32'(silent), 32'(TIMEOUT));
        check("timeout_err", 32'(err), 32'b100);
        check("timeout_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        $display("[TB] timeout after %0d silent cycles: err=%0b", silent, err);

        // Abort on the 4th LOAD cycle, then a full frame.
        cfg_wr = 1'b1; cfg_src = 1'b0; cfg_scaling = 6'h12; start = 1'b1;
        tick();
        cfg_wr = 1'b0; start = 1'b0; in_valid = 1'b1;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_readys", 32'({in_ready, par_ready}), 32'd0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        check("abort_err", 32'(err), 32'd0);
        $display("[TB] abort: busy=%0d frame_cnt=%0d", busy, frame_cnt);
        tick();
        run_frame(1'b0, 6'h12, 0, 1'b0, 1'b0);

        // Randomized frames, some with outputs overlapping the load phase.
        for (int k = 0; k < 8; k++) begin
            run_frame(1'($urandom_range(1)), 6'($urandom), 2, 1'b1, 1'($urandom_range(1)));
        end
        // Boundary: final input and final output on the same edge.
        run_frame(1'b1, 6'h21, 0, 1'b0, 1'b1);

        // Asynchronous reset mid-DRAIN.
        load_phase(1'b1, 6'h2a, 0, 1'b0, 1'b0, osent, lc);
        repeat (3) begin
            last_valid = 1'b1;
            tick();
        end
        last_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_readys", 32'({in_ready, par_ready}), 32'd0);
        check("arst_select", 32'(select), 32'd0);
        check("arst_scaling", 32'(scaling), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        $display("[TB] async reset mid-DRAIN: busy=%0d frame_cnt=%0d", busy, frame_cnt);
        @(negedge clk);
        rst = 1'b0;
        exp_fcnt = 0;
        tick();
        last_valid = 1'b1;
        tick();
        last_valid = 1'b0;
        tick();
        check("spurious_err", 32'(err), 32'b010);
        $display("[TB] last_valid in IDLE: err=%0b", err);

        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
